// File: rtl/mul_add_pipe_if.sv
// Handshake bundle for mul_add_pipe: operand channel (in_valid/in_ready/x/y/z),
// result channel (out_valid/out_ready/out) and the busy status flag.
// master = producer/consumer side, slave = the pipeline itself.
interface mul_add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/mul_add_pipe.sv
// mul_add_pipe: STAGES-deep pipelined out = x*y + z on unsigned WIDTH-bit operands.
// Stage 1 holds the operands, stage 2 the full-width product plus addend, middle
// stages only delay, and the last stage holds the final sum. All stages move
// together under a single global advance signal (stall when the output is held).
// Optional build macro MUL_ADD_PIPE_SAT_EN: clamp the result to 2^WIDTH-1 instead
// of wrapping when the full-precision sum overflows. Latency and handshake are
// the same either way.
module mul_add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input logic         clk,
  input logic         rst,
  mul_add_pipe_if.slave bus
);

  localparam int PW  = 2 * WIDTH;
  localparam int MID = (STAGES > 2) ? (STAGES - 2) : 1;

  logic [STAGES-1:0] vld;
  logic              advance;
  logic              accept;
  logic [WIDTH-1:0]  s1_x;
  logic [WIDTH-1:0]  s1_y;
  logic [WIDTH-1:0]  s1_z;
  logic [PW-1:0]     s1_prod;
  logic [WIDTH-1:0]  res;

  // Final add is done at 2*WIDTH+1 bits so overflow is visible for clamping.
  function automatic logic [WIDTH-1:0] sum_result(input logic [PW-1:0] prod,
                                                  input logic [WIDTH-1:0] addend);
    logic [PW:0] full;
    full = {1'b0, prod} + {{(PW + 1 - WIDTH){1'b0}}, addend};
`ifdef MUL_ADD_PIPE_SAT_EN
    if (|full[PW:WIDTH]) begin
      return '1;
    end
    return full[WIDTH-1:0];
`else
    return full[WIDTH-1:0];
`endif
  endfunction

  assign advance       = !vld[STAGES-1] || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign s1_prod       = PW'(s1_x) * PW'(s1_y);
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out       = res;
  assign bus.busy      = |vld;

  // Valid bits shift as one; an idle advancing cycle inserts a bubble at stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (advance) begin
      if (STAGES > 1) begin
        vld <= {vld[STAGES-2:0], accept};
      end
    end
  end

  // Stage 1 captures operands; inputs are ignored while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x <= '0;
      s1_y <= '0;
      s1_z <= '0;
    end else if (advance) begin
      s1_x <= bus.x;
      s1_y <= bus.y;
      s1_z <= bus.z;
    end
  end

  generate
    if (STAGES == 2) begin : g_short
      // Two-stage build: product and add share the final register stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res <= '0;
        end else if (advance) begin
          res <= sum_result(s1_prod, s1_z);
        end
      end
    end else begin : g_long
      logic [PW-1:0]    mid_prod [MID];
      logic [WIDTH-1:0] mid_z    [MID];

      // Stage 2 registers product and addend; following entries are pure delay.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MID; i++) begin
            mid_prod[i] <= '0;
            mid_z[i]    <= '0;
          end
        end else if (advance) begin
          mid_prod[0] <= s1_prod;
          mid_z[0]    <= s1_z;
          for (int i = 1; i < MID; i++) begin
            mid_prod[i] <= mid_prod[i-1];
            mid_z[i]    <= mid_z[i-1];
          end
        end
      end

      // Last stage registers the finished sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res <= '0;
        end else if (advance) begin
          res <= sum_result(mid_prod[MID-1], mid_z[MID-1]);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mul_add_pipe.sv
// Directed bench for mul_add_pipe: a 32-bit/3-stage instance carries most vectors,
// an 8-bit/5-stage instance checks deep latency and narrow overflow.
// Build with MUL_ADD_PIPE_SAT_EN defined to expect the saturating results.
module tb_mul_add_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_add_pipe_if #(.WIDTH(32)) ia ();
  mul_add_pipe_if #(.WIDTH(8))  ib ();

  mul_add_pipe #(.WIDTH(32), .STAGES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  mul_add_pipe #(.WIDTH(8), .STAGES(5)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

`ifdef MUL_ADD_PIPE_SAT_EN
  localparam logic [31:0] EXP_BIG   = 32'hFFFF_FFFF;
  localparam logic [7:0]  EXP_NARROW = 8'd255;
`else
  localparam logic [31:0] EXP_BIG   = 32'h0000_0003;
  localparam logic [7:0]  EXP_NARROW = 8'd1;
`endif

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the 32-bit instance, check outputs mid-cycle, then advance.
  task automatic apply_stimulus(input string tag, input logic iv,
                                input logic [31:0] xx, input logic [31:0] yy,
                                input logic [31:0] zz, input logic ordy,
                                input logic exp_ov, input logic [31:0] exp_out,
                                input logic exp_ir);
    ia.in_valid  = iv;
    ia.x         = xx;
    ia.y         = yy;
    ia.z         = zz;
    ia.out_ready = ordy;
    #2;
    check_output({tag, ".out_valid"}, 64'(ia.out_valid), 64'(exp_ov));
    check_output({tag, ".in_ready"}, 64'(ia.in_ready), 64'(exp_ir));
    if (exp_ov) begin
      check_output({tag, ".out"}, 64'(ia.out), 64'(exp_out));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] squares [8];
    checks = 0;
    errors = 0;
    squares = '{32'd1, 32'd2, 32'd5, 32'd10, 32'd17, 32'd26, 32'd37, 32'd50};

    rst = 1'b0;
    ia.in_valid = 1'b0; ia.x = '0; ia.y = '0; ia.z = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.x = '0; ib.y = '0; ib.z = '0; ib.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_output("reset.out_valid", 64'(ia.out_valid), 64'd0);
    check_output("reset.busy", 64'(ia.busy), 64'd0);
    check_output("reset.in_ready", 64'(ia.in_ready), 64'd1);
    check_output("reset.out", 64'(ia.out), 64'd0);
    check_output("reset.out8", 64'(ib.out), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single transaction: 3*5+7 = 22 visible in cycle 3 only.
    apply_stimulus("single_c0", 1'b1, 32'd3, 32'd5, 32'd7, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("single_c1", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("single_c2", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("single_c3", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd22, 1'b1);
    apply_stimulus("single_c4", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Back-to-back i*i+1 for i=0..7, results on consecutive cycles.
    for (int c = 0; c < 11; c++) begin
      logic        ov;
      logic [31:0] eo;
      ov = (c >= 3) && (c <= 10);
      eo = ov ? squares[c-3] : 32'd0;
      apply_stimulus($sformatf("stream_c%0d", c), c < 8, 32'(c), 32'(c), 32'd1,
                     1'b1, ov, eo, 1'b1);
    end
    #2;
    check_output("stream.busy_after", 64'(ia.busy), 64'd0);
    check_output("stream.out_valid_after", 64'(ia.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Fill with 2k+1 for k=1..4, stall 4 cycles while offering junk, then drain.
    apply_stimulus("stall_c0", 1'b1, 32'd1, 32'd2, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("stall_c1", 1'b1, 32'd2, 32'd2, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("stall_c2", 1'b1, 32'd3, 32'd2, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("stall_c3", 1'b1, 32'd4, 32'd2, 32'd1, 1'b1, 1'b1, 32'd3, 1'b1);
    for (int c = 4; c < 8; c++) begin
      apply_stimulus($sformatf("stall_c%0d", c), 1'b1, 32'd99, 32'd99, 32'd99,
                     1'b0, 1'b1, 32'd5, 1'b0);
    end
    apply_stimulus("stall_c8", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b1);
    apply_stimulus("stall_c9", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd7, 1'b1);
    apply_stimulus("stall_c10", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd9, 1'b1);
    apply_stimulus("stall_c11", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    check_output("stall.busy_after", 64'(ia.busy), 64'd0);

    // Full-scale operands: overflow of the 64-bit product plus addend.
    apply_stimulus("big_c0", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b1,
                   1'b0, 32'd0, 1'b1);
    apply_stimulus("big_c1", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("big_c2", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("big_c3", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, EXP_BIG, 1'b1);

    // Reset with two transactions in flight; neither may ever emerge.
    apply_stimulus("rst_a", 1'b1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("rst_b", 1'b1, 32'd6, 32'd6, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    ia.in_valid = 1'b0;
    #2;
    check_output("rst.busy_before", 64'(ia.busy), 64'd1);
    rst = 1'b1;
    #1;
    check_output("rst.busy_now", 64'(ia.busy), 64'd0);
    check_output("rst.out_valid_now", 64'(ia.out_valid), 64'd0);
    check_output("rst.in_ready_now", 64'(ia.in_ready), 64'd1);
    check_output("rst.out_now", 64'(ia.out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      apply_stimulus($sformatf("rst_idle%0d", c), 1'b0, 32'd0, 32'd0, 32'd0, 1'b1,
                     1'b0, 32'd0, 1'b1);
    end
    apply_stimulus("post_c0", 1'b1, 32'd2, 32'd2, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("post_c1", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("post_c2", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    apply_stimulus("post_c3", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b1);
    apply_stimulus("post_c4", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Narrow, deep instance: 16*16+1 overflows 8 bits, latency 5.
    ib.in_valid = 1'b1;
    ib.x = 8'd16;
    ib.y = 8'd16;
    ib.z = 8'd1;
    @(posedge clk);
    #1;
    ib.in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check_output($sformatf("narrow_c%0d.out_valid", c), 64'(ib.out_valid),
                   64'(c == 5));
      if (c == 5) begin
        check_output("narrow_c5.out", 64'(ib.out), 64'(EXP_NARROW));
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_pipe.md
MUL_ADD_PIPE -- requirements
Module: mul_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 3: accept-to-output latency in cycles, legal range 2..8.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand triple offered.
REQ-006 SHALL have port in_ready, output, 1: pipeline can accept this cycle.
REQ-007 SHALL have ports x, y, z, input, WIDTH each: operands.
REQ-008 SHALL have port out_valid, output, 1: out holds a result.
REQ-009 SHALL have port out_ready, input, 1: consumer takes out this cycle.
REQ-010 SHALL have port out, output, WIDTH: result.
REQ-011 SHALL have port busy, output, 1: high when any stage holds a valid entry.

Function
REQ-012 SHALL compute out = (x*y + z) mod 2^WIDTH, all operands unsigned; the product is formed at full 2*WIDTH width before truncation.
REQ-013 SHALL be a STAGES-deep register pipeline with one valid bit per stage; stage 1 registers x, y, z; stage 2 registers the product and z; the add result is registered in stage STAGES; stages between are pure delay.
REQ-014 SHALL use global stall: advance = !out_valid || out_ready; all stages shift together only when advance is high.
REQ-015 SHALL drive in_ready = advance combinationally; no other combinational path from inputs to outputs.
REQ-016 SHALL accept a transaction when in_valid && in_ready; a cycle with advance high and no accept inserts a bubble (valid 0) into stage 1.
REQ-017 SHALL present an accepted transaction on out with out_valid high exactly STAGES cycles after acceptance when out_ready is held high.
REQ-018 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL preserve order; no transaction is dropped or duplicated under any stall pattern.
REQ-020 SHALL sustain one transaction per cycle when out_ready is held high.
REQ-021 SHALL ignore x, y, z and in_valid in cycles where in_ready is low.
REQ-022 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-023 SHALL on rst clear all stage valid bits immediately (asynchronously), giving out_valid=0, busy=0, in_ready=1.
REQ-024 SHALL reset out and all data registers to 0.
REQ-025 SHALL discard all in-flight transactions when rst asserts mid-operation; the first accept after rst deasserts yields the first post-reset result.

Configuration
REQ-026 SHALL, when macro MUL_ADD_PIPE_SAT_EN is defined, saturate the result: if the full-precision x*y + z exceeds 2^WIDTH-1, out = 2^WIDTH-1.
REQ-027 SHALL, when MUL_ADD_PIPE_SAT_EN is undefined, wrap modulo 2^WIDTH per REQ-012; latency and handshake are identical in both builds.

Verification
REQ-028 WIDTH=32, STAGES=3, out_ready=1: accept x=3, y=5, z=7 at cycle 0 -> out=22, out_valid=1 at cycle 3 only.
REQ-029 Back-to-back 8 accepts x=i, y=i, z=1 for i=0..7, out_ready=1 -> outputs 1,2,5,10,17,26,37,50 on consecutive cycles, busy low after the last.
REQ-030 Pipeline full, out_ready=0 for 4 cycles -> in_ready=0, out and out_valid stable; on release, remaining results emerge in order with no loss.
REQ-031 x=y=0xFFFFFFFF, z=2 -> wrap build out=0x00000003; MUL_ADD_PIPE_SAT_EN build out=0xFFFFFFFF.
REQ-032 rst pulsed with 2 transactions in flight -> out_valid=0, busy=0 immediately; neither result ever appears; next accept x=2, y=2, z=0 yields 4 after STAGES cycles.
REQ-033 WIDTH=8, STAGES=5: x=16, y=16, z=1 -> wrap out=1, saturate out=255, at latency 5.
